// File: rtl/number_seq_core.sv
// -----------------------------------------------------------------------------
// number_seq_core
//   Stepped number-sequence generator. A prescaler paces the steps. On each
//   step the sequence value advances in one of four modes: up count, down
//   count, Fibonacci LFSR, or hold. 'out' is a running sum of the sequence
//   values.
//
//   Build option NUMBER_SEQ_GRAY_OUT_EN:
//     When defined, 'out' is instead the registered Gray code of 'number'.
//     It is updated on every step and on every load, and no accumulator
//     is built.
//
// Parameters:
//   WIDTH   - width of number / out / load_val
//   DIV     - clock cycles per step while en is high (>= 1)
//   TAPS    - LFSR feedback mask, bit i set = tap on number[i]
//   RST_VAL - reset value of number
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active low
//   en       in   step enable; the prescaler only advances while high
//   mode     in   00 up, 01 down, 10 LFSR, 11 hold (sampled on step edges)
//   load     in   synchronous load of load_val; this beats a coincident step
//   load_val in   value loaded into number
//   number   out  current sequence value
//   out      out  accumulated sum of numbers (or Gray code of number)
//   step     out  pulse in the first cycle a new number is visible
//   wrap     out  pulse together with step when an up/down count wraps
// -----------------------------------------------------------------------------
module number_seq_core #(
  parameter int               WIDTH   = 8,
  parameter int               DIV     = 4,
  parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] number,
  output logic [WIDTH-1:0] out,
  output logic             step,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic [WIDTH-1:0] number_q, number_d;
  logic [WIDTH-1:0] out_q;
  logic             step_q, wrap_q;
  logic             wrap_d;
  logic             tick;

  function automatic logic [WIDTH-1:0] gray(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Prescaler: with DIV == 1, CNT_MAX is 0 and every enabled cycle ticks.
  assign tick = en && (div_cnt_q == CNT_MAX);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (en) div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
  end

  // Next sequence value. This is only used on tick edges, so mode only
  // matters at a step.
  always_comb begin
    number_d = number_q;
    wrap_d   = 1'b0;
    case (mode_e'(mode))
      MODE_UP: begin
        number_d = number_q + WIDTH'(1);
        wrap_d   = (number_q == '1);
      end
      MODE_DOWN: begin
        number_d = number_q - WIDTH'(1);
        wrap_d   = (number_q == '0);
      end
      MODE_LFSR: begin
        // An all-zero register would stay stuck at zero, so force it to 1.
        if (number_q == '0) number_d = WIDTH'(1);
        else                number_d = {number_q[WIDTH-2:0], ^(number_q & TAPS)};
      end
      MODE_HOLD: number_d = number_q;
      default:   number_d = number_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      number_q  <= RST_VAL;
      out_q     <= '0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (load) begin
      // A load discards any step that falls on the same edge.
      div_cnt_q <= '0;
      number_q  <= load_val;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
`ifdef NUMBER_SEQ_GRAY_OUT_EN
      out_q     <= gray(load_val);
`endif
    end else begin
      div_cnt_q <= div_cnt_d;
      step_q    <= tick;
      wrap_q    <= tick && wrap_d;
      if (tick) begin
        number_q <= number_d;
`ifdef NUMBER_SEQ_GRAY_OUT_EN
        out_q    <= gray(number_d);
`else
        out_q    <= out_q + number_q;   // accumulates the pre-step value
`endif
      end
    end
  end

  assign number = number_q;
  assign out    = out_q;
  assign step   = step_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_number_seq_core.sv
// -----------------------------------------------------------------------------
// tb_number_seq_core
//   Directed bench for number_seq_core. u_dut (DIV=4) covers the counting
//   modes, pausing, and reset. u_d2 (DIV=2) shares the same inputs and covers
//   a load that lands on a step edge. Expected 'out' values follow the build:
//   a running sum by default, or Gray code with NUMBER_SEQ_GRAY_OUT_EN.
// -----------------------------------------------------------------------------
module tb_number_seq_core;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] n1, o1, n2, o2;
  logic         s1, w1, s2, w2;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench model of the u_dut sequence value and accumulator.
  logic [W-1:0] m_num, m_acc;

  number_seq_core #(.WIDTH(W), .DIV(4), .TAPS(8'hB8), .RST_VAL(8'h00)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .number(n1), .out(o1), .step(s1), .wrap(w1)
  );

  number_seq_core #(.WIDTH(W), .DIV(2), .TAPS(8'hB8), .RST_VAL(8'h00)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .number(n2), .out(o2), .step(s2), .wrap(w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_out(input logic [W-1:0] num, input logic [W-1:0] acc);
`ifdef NUMBER_SEQ_GRAY_OUT_EN
    return num ^ (num >> 1);
`else
    return acc + (num & 8'h00);
`endif
  endfunction

  // Advance n clock edges, then sample 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full DIV=4 step period, starting with div_cnt == 0.
  task automatic do_tick(input logic [W-1:0] exp_num, input logic exp_wrap, input string tag);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk({tag, "_idle_step"}, W'(s1), 8'h00);
      chk({tag, "_idle_num"},  n1, m_num);
    end
    cyc(1);
    m_acc = m_acc + m_num;
    m_num = exp_num;
    chk({tag, "_step"}, W'(s1), 8'h01);
    chk({tag, "_num"},  n1, m_num);
    chk({tag, "_wrap"}, W'(w1), W'(exp_wrap));
    chk({tag, "_out"},  o1, exp_out(m_num, m_acc));
  endtask

  task automatic do_load(input logic [W-1:0] val, input string tag);
    load     = 1'b1;
    load_val = val;
    cyc(1);
    load     = 1'b0;
    m_num    = val;
    chk({tag, "_num"},  n1, val);
    chk({tag, "_step"}, W'(s1), 8'h00);
    chk({tag, "_wrap"}, W'(w1), 8'h00);
    chk({tag, "_out"},  o1, exp_out(m_num, m_acc));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
    m_num = '0; m_acc = '0;

    // Reset state
    cyc(2);
    chk("rst_num", n1, 8'h00);
    chk("rst_out", o1, 8'h00);
    chk("rst_step", W'(s1), 8'h00);
    chk("rst_wrap", W'(w1), 8'h00);

    // Up count: 1,2,3,4 with out 0,1,3,6 (sum build)
    rst = 1'b1; en = 1'b1; mode = 2'b00;
    do_tick(8'h01, 1'b0, "up1");
    do_tick(8'h02, 1'b0, "up2");
    do_tick(8'h03, 1'b0, "up3");
    do_tick(8'h04, 1'b0, "up4");

    // Up wrap FE -> FF -> 00
    do_load(8'hFE, "ld_fe");
    do_tick(8'hFF, 1'b0, "upw1");
    do_tick(8'h00, 1'b1, "upw2");
    cyc(1);
    chk("upw_step_drop", W'(s1), 8'h00);
    chk("upw_wrap_drop", W'(w1), 8'h00);

    // Down wrap 01 -> 00 -> FF
    mode = 2'b01;
    do_load(8'h01, "ld_01");
    do_tick(8'h00, 1'b0, "dn1");
    do_tick(8'hFF, 1'b1, "dn2");

    // LFSR from 00: escape to 01, then shift with TAPS=B8 feedback
    // (bit3 is a tap, so 08 -> 11 and 11 -> 23).
    mode = 2'b10;
    do_load(8'h00, "ld_00");
    do_tick(8'h01, 1'b0, "lf1");
    do_tick(8'h02, 1'b0, "lf2");
    do_tick(8'h04, 1'b0, "lf3");
    do_tick(8'h08, 1'b0, "lf4");
    do_tick(8'h11, 1'b0, "lf5");
    do_tick(8'h23, 1'b0, "lf6");

    // Hold: number unchanged, step still pulses, out still accumulates
    mode = 2'b11;
    do_tick(8'h23, 1'b0, "hold");

    // Pause with div_cnt == 2: two enabled edges are left before the step.
    mode = 2'b00;
    cyc(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("pause_num", n1, 8'h23);
      chk("pause_step", W'(s1), 8'h00);
    end
    en = 1'b1;
    cyc(1);
    chk("resume_nostep", W'(s1), 8'h00);
    cyc(1);
    m_acc = m_acc + m_num;
    m_num = 8'h24;
    chk("resume_step", W'(s1), 8'h01);
    chk("resume_num", n1, m_num);
    chk("resume_out", o1, exp_out(m_num, m_acc));

    // Async reset between clock edges
    #2 rst = 1'b0;
    #1;
    chk("arst_num", n1, 8'h00);
    chk("arst_out", o1, 8'h00);
    chk("arst_step", W'(s1), 8'h00);
    chk("arst_wrap", W'(w1), 8'h00);
    chk("arst_num2", n2, 8'h00);
    cyc(1);
    chk("arst_hold_num", n1, 8'h00);

    // Load vs tick on the DIV=2 instance
    rst = 1'b1; en = 1'b1; mode = 2'b00;
    cyc(1);                                   // div_cnt 0 -> 1
    chk("col_pre_step", W'(s2), 8'h00);
    load = 1'b1; load_val = 8'h55;
    cyc(1);                                   // tick edge, load wins
    load = 1'b0;
    chk("col_num", n2, 8'h55);
    chk("col_step", W'(s2), 8'h00);
    chk("col_out", o2, exp_out(8'h55, 8'h00));
    cyc(1);
    chk("col_gap_step", W'(s2), 8'h00);
    cyc(1);
    chk("col_next_step", W'(s2), 8'h01);
    chk("col_next_num", n2, 8'h56);
    chk("col_next_out", o2, exp_out(8'h56, 8'h55));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
